// File: rtl/ofifo_drain_ctrl_if.sv
// Bus between the ofifo drain sequencer, the systolic-array output FIFO and the psum SRAM.
// master = drain controller, slave = ofifo/SRAM side.
interface ofifo_drain_ctrl_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_w  = 11
);
  logic                     ofifo_valid;
  logic                     ofifo_full;
  logic [col*psum_bw-1:0]   ofifo_out;
  logic                     ofifo_rd;
  logic                     sram_cen_n;
  logic                     sram_wen_n;
  logic [addr_w-1:0]        sram_addr;
  logic [col*psum_bw-1:0]   sram_d;

  modport master (
    input  ofifo_valid, ofifo_full, ofifo_out,
    output ofifo_rd, sram_cen_n, sram_wen_n, sram_addr, sram_d
  );

  modport slave (
    output ofifo_valid, ofifo_full, ofifo_out,
    input  ofifo_rd, sram_cen_n, sram_wen_n, sram_addr, sram_d
  );
endinterface

// File: rtl/ofifo_drain_ctrl.sv
// Drains ofifo rows into consecutive psum SRAM addresses after a start pulse, then pulses done.
// Optional OFIFO_DRAIN_PERF_EN adds a saturating stall_cnt output.
module ofifo_drain_ctrl #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_w  = 11,
  parameter int cnt_w   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [cnt_w-1:0]  num_rows,
  input  logic [addr_w-1:0] base_addr,
  ofifo_drain_ctrl_if.master dbus,
  output logic              busy,
  output logic              done,
  output logic              err_full_idle
`ifdef OFIFO_DRAIN_PERF_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

  state_t                 state_q, state_d;
  logic [cnt_w-1:0]       remaining_q, remaining_d;
  logic [addr_w-1:0]      wr_ptr_q, wr_ptr_d;
  logic [addr_w-1:0]      addr_q, addr_d;
  logic [col*psum_bw-1:0] data_q, data_d;
  logic                   cen_n_q, cen_n_d;
  logic                   wen_n_q, wen_n_d;
  logic                   err_q, err_d;
  logic                   rd;
  logic                   accept;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    wr_ptr_d    = wr_ptr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    cen_n_d     = 1'b1;
    wen_n_d     = 1'b1;
    err_d       = err_q;
    accept      = (state_q == IDLE) && start;
    rd          = (state_q == DRAIN) && dbus.ofifo_valid && (remaining_q != '0);

    case (state_q)
      IDLE: begin
        if (accept) begin
          remaining_d = num_rows;
          wr_ptr_d    = base_addr;
          err_d       = 1'b0;
          state_d     = (num_rows == '0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        // The registered strobes double as the write-pending flag for the next cycle.
        if (rd) begin
          data_d      = dbus.ofifo_out;
          remaining_d = remaining_q - cnt_w'(1);
          cen_n_d     = 1'b0;
          wen_n_d     = 1'b0;
          addr_d      = wr_ptr_q;
          wr_ptr_d    = wr_ptr_q + addr_w'(1);
          if (remaining_q == cnt_w'(1)) state_d = FLUSH;
        end
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Setting has priority over the clear from an accepted start.
    if ((state_q == IDLE) && dbus.ofifo_full) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      wr_ptr_q    <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      cen_n_q     <= 1'b1;
      wen_n_q     <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      wr_ptr_q    <= wr_ptr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cen_n_q     <= cen_n_d;
      wen_n_q     <= wen_n_d;
      err_q       <= err_d;
    end
  end

`ifdef OFIFO_DRAIN_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (accept) begin
      stall_d = '0;
    end else if ((state_q == DRAIN) && !dbus.ofifo_valid && (remaining_q != '0)
                 && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

  assign dbus.ofifo_rd   = rd;
  assign dbus.sram_cen_n = cen_n_q;
  assign dbus.sram_wen_n = wen_n_q;
  assign dbus.sram_addr  = addr_q;
  assign dbus.sram_d     = data_q;
  assign busy            = (state_q == DRAIN) || (state_q == FLUSH);
  assign done            = (state_q == DONE);
  assign err_full_idle   = err_q;

endmodule

// File: tb/tb_ofifo_drain_ctrl.sv
// Randomized/directed bench for ofifo_drain_ctrl against a job-level reference model.
// Honours OFIFO_DRAIN_PERF_EN for the stall counter.
module tb_ofifo_drain_ctrl;
  localparam int COL = 8, PSUM_BW = 16, ADDR_W = 11, CNT_W = 8, DW = COL * PSUM_BW;
  localparam int FAR = 1 << 30;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic start = 1'b0;
  logic [CNT_W-1:0] num_rows = '0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic busy, done, err_full_idle;
`ifdef OFIFO_DRAIN_PERF_EN
  logic [15:0] stall_cnt;
`endif

  ofifo_drain_ctrl_if #(.col(COL), .psum_bw(PSUM_BW), .addr_w(ADDR_W)) dbus ();

  ofifo_drain_ctrl #(.col(COL), .psum_bw(PSUM_BW), .addr_w(ADDR_W), .cnt_w(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_rows(num_rows), .base_addr(base_addr),
    .dbus(dbus), .busy(busy), .done(done), .err_full_idle(err_full_idle)
`ifdef OFIFO_DRAIN_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a job accepted in cycle s pops on the first N later cycles with valid,
  // each pop lands as a write one cycle later, done follows the final write by one cycle.
  typedef struct {int at; logic [ADDR_W-1:0] addr; logic [DW-1:0] data;} wr_t;
  wr_t wq[$];
  int cyc = 0;
  int busy_from, busy_until, job_start, done_at, rows_left, pops = 0;
  logic [ADDR_W-1:0] next_addr, last_addr;
  logic [DW-1:0] last_data;
  bit err_m;
  int stall_m;

  function automatic bit m_busy(int c);
    return (c >= busy_from) && (c <= busy_until);
  endfunction

  function automatic bit m_idle(int c);
    return !((c >= job_start) && (c <= done_at));
  endfunction

  task automatic model_reset();
    wq.delete();
    busy_from = -100; busy_until = -101; job_start = -100; done_at = -100;
    rows_left = 0; next_addr = '0; last_addr = '0; last_data = '0;
    err_m = 1'b0; stall_m = 0;
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic st, input int nr, input int ba, input logic v, input logic f);
    start = st;
    num_rows = CNT_W'(nr);
    base_addr = ADDR_W'(ba);
    dbus.ofifo_valid = v;
    dbus.ofifo_full = f;
    dbus.ofifo_out = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic check_reset();
    checkOutput("rst_rd", dbus.ofifo_rd, 0);
    checkOutput("rst_cen_n", dbus.sram_cen_n, 1);
    checkOutput("rst_wen_n", dbus.sram_wen_n, 1);
    checkOutput("rst_addr", dbus.sram_addr, 0);
    checkOutput("rst_d", dbus.sram_d, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err_full_idle, 0);
`ifdef OFIFO_DRAIN_PERF_EN
    checkOutput("rst_stall", stall_cnt, 0);
`endif
  endtask

  // One clock: check this cycle's outputs at the falling edge, then advance the model.
  task automatic cycle();
    logic exp_rd, exp_wr;
    logic [ADDR_W-1:0] ea;
    logic [DW-1:0] ed;
    @(negedge clk);
    exp_rd = m_busy(cyc) && (rows_left > 0) && dbus.ofifo_valid;
    exp_wr = (wq.size() > 0) && (wq[0].at == cyc);
    ea = exp_wr ? wq[0].addr : last_addr;
    ed = exp_wr ? wq[0].data : last_data;
    checkOutput("ofifo_rd", dbus.ofifo_rd, exp_rd);
    checkOutput("sram_cen_n", dbus.sram_cen_n, !exp_wr);
    checkOutput("sram_wen_n", dbus.sram_wen_n, !exp_wr);
    checkOutput("sram_addr", dbus.sram_addr, ea);
    checkOutput("sram_d", dbus.sram_d, ed);
    checkOutput("busy", busy, m_busy(cyc));
    checkOutput("done", done, cyc == done_at);
    checkOutput("err_full_idle", err_full_idle, err_m);
`ifdef OFIFO_DRAIN_PERF_EN
    checkOutput("stall_cnt", stall_cnt, 16'(stall_m));
`endif
    @(posedge clk);
    if (exp_wr) begin
      last_addr = ea;
      last_data = ed;
      void'(wq.pop_front());
    end
    if (m_busy(cyc) && (rows_left > 0) && !dbus.ofifo_valid && (stall_m < 65535)) stall_m++;
    if (m_idle(cyc)) begin
      if (start) begin
        job_start = cyc;
        rows_left = int'(num_rows);
        next_addr = base_addr;
        err_m = 1'b0;
        stall_m = 0;
        busy_from = cyc + 1;
        if (num_rows == '0) begin
          busy_until = cyc;
          done_at = cyc + 1;
        end else begin
          busy_until = FAR;
          done_at = FAR;
        end
      end
      if (dbus.ofifo_full) err_m = 1'b1;
    end
    if (exp_rd) begin
      wq.push_back('{cyc + 1, next_addr, dbus.ofifo_out});
      next_addr = next_addr + ADDR_W'(1);
      rows_left--;
      pops++;
      if (rows_left == 0) begin
        busy_until = cyc + 1;
        done_at = cyc + 2;
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    int p0;
    dbus.ofifo_valid = 1'b0;
    dbus.ofifo_full = 1'b0;
    dbus.ofifo_out = '0;
    model_reset();

    // Reset held with random inputs
    #2 reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'($urandom), $urandom_range(0, 255), $urandom, 1'($urandom), 1'($urandom));
      @(negedge clk);
      check_reset();
    end
    applyStimulus(0, 0, 0, 0, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) begin
      applyStimulus(0, $urandom_range(0, 9), $urandom, 1'($urandom), 0);
      cycle();
    end

    // Basic drain: 4 rows from 16, valid held high
    applyStimulus(1, 4, 16, 1, 0);
    cycle();
    repeat (8) begin applyStimulus(0, 0, 0, 1, 0); cycle(); end

    // Stalled drain
    begin
      logic [5:0] pat;
      pat = 6'b101001;
      applyStimulus(1, 3, $urandom, 0, 0);
      cycle();
      for (int i = 0; i < 6; i++) begin applyStimulus(0, 0, 0, pat[i], 0); cycle(); end
      repeat (3) begin applyStimulus(0, 0, 0, 0, 0); cycle(); end
`ifdef OFIFO_DRAIN_PERF_EN
      checkOutput("stall_total", stall_cnt, 3);
`endif
    end

    // Zero rows, then address wrap
    applyStimulus(1, 0, 100, 1, 0);
    cycle();
    repeat (3) begin applyStimulus(0, 0, 0, 1, 0); cycle(); end
    applyStimulus(1, 3, 2046, 1, 0);
    cycle();
    repeat (7) begin applyStimulus(0, 0, 0, 1, 0); cycle(); end

    // Start mid-job and start coinciding with done are both ignored
    applyStimulus(1, 2, 500, 0, 0);
    cycle();
    applyStimulus(1, 9, 7, 1, 0);
    cycle();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(cyc == done_at, 9, 7, 1, 0);
      cycle();
    end

    // Error flag: set in idle, held, cleared by start, set wins when coincident
    applyStimulus(0, 0, 0, 0, 1); cycle();
    repeat (3) begin applyStimulus(0, 0, 0, 0, 0); cycle(); end
    applyStimulus(1, 1, 40, 0, 0); cycle();
    repeat (4) begin applyStimulus(0, 0, 0, 1, 1); cycle(); end
    applyStimulus(1, 0, 0, 0, 1); cycle();
    repeat (3) begin applyStimulus(0, 0, 0, 0, 0); cycle(); end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 6), $urandom,
                    $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
      cycle();
    end
    repeat (12) begin applyStimulus(0, 0, 0, 1, 0); cycle(); end

    // Mid-job asynchronous reset after two pops
    applyStimulus(1, 5, $urandom, 1, 0);
    cycle();
    p0 = pops;
    applyStimulus(0, 0, 0, 1, 0);
    for (int i = 0; i < 20 && pops < p0 + 2; i++) cycle();
    if (pops < p0 + 2) begin
      checks++;
      errors++;
      $error("[TB] FAIL pop_wait: observed=%0d pops expected=%0d", pops - p0, 2);
    end
    reset_n = 1'b0;
    #1;
    check_reset();
    model_reset();
    @(negedge clk);
    check_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    applyStimulus(0, 0, 0, 1, 0); cycle();
    applyStimulus(1, 3, 1234, 1, 0); cycle();
    repeat (7) begin applyStimulus(0, 0, 0, 1, 0); cycle(); end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
